sdram_burst_scheduler: RTL and testbench

//  Sequences SDRAM burst traffic for the frame buffer. Watches the write-port FIFO (LCD capture)
//  and read-port FIFO (LCD output) fill levels and issues one read or write burst command at a

---
 rtl/sdram_burst_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sdram_burst_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_scheduler.sv
// sdram_burst_scheduler
// Picks one SDRAM burst at a time (write from the capture FIFO or read for the
// display FIFO), tracks per-port frame addresses with frame wrap, and manages
// the ping-pong frame banks. Runs in the controller clock domain.
// Optional feature macro: READ_URGENT_EN. When defined, a read whose FIFO level
// is below URGENT_LVL wins arbitration outright. Undefined, arbitration is
// pure round-robin.
module sdram_burst_scheduler #(
    parameter int ADDR_W        = 24,
    parameter int LEN_W         = 10,
    parameter int RD_FIFO_DEPTH = 512,
    parameter int URGENT_LVL    = 64
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic              read_valid,
    input  logic              pingpong,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [ADDR_W-1:0] wr_min_addr,
    input  logic [ADDR_W-1:0] wr_max_addr,
    input  logic [ADDR_W-1:0] rd_min_addr,
    input  logic [ADDR_W-1:0] rd_max_addr,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic [LEN_W-1:0]  wr_fifo_cnt,
    input  logic [LEN_W-1:0]  rd_fifo_cnt,
    output logic              cmd_valid,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              frame_wr_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_REQ  = 2'd2,
        ST_BUSY = 2'd3
    } state_t;

    localparam logic [LEN_W:0] DEPTH_X = (LEN_W+1)'(RD_FIFO_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_bank;
    logic              rd_bank;
    logic              last_grant_write;   // 1 = last grant went to the write port
    logic              wr_load_pend;
    logic              rd_load_pend;

    logic [LEN_W-1:0]  wr_len;
    logic [LEN_W-1:0]  rd_len;
    logic              wr_elig;
    logic              rd_elig;
    logic              grant;
    logic              grant_write;
    logic              burst_done;
    logic              wr_inflight;
    logic              rd_inflight;
    logic [ADDR_W-1:0] wr_next;
    logic [ADDR_W-1:0] rd_next;
    logic [ADDR_W-1:0] len_ext;

    // Burst length clipped to the words left before the frame end.
    function automatic logic [LEN_W-1:0] clip_len(
        input logic [LEN_W-1:0]  nominal,
        input logic [ADDR_W-1:0] max_a,
        input logic [ADDR_W-1:0] cur_a
    );
        logic [ADDR_W-1:0] remain;
        logic [ADDR_W-1:0] nominal_ext;
        remain      = max_a - cur_a;
        nominal_ext = {{(ADDR_W-LEN_W){1'b0}}, nominal};
        if (remain < nominal_ext) begin
            clip_len = remain[LEN_W-1:0];
        end else begin
            clip_len = nominal;
        end
    endfunction

    // Per-port burst sizing, eligibility and post-burst address arithmetic.
    always_comb begin
        wr_len      = clip_len(burst_len, wr_max_addr, wr_addr);
        rd_len      = clip_len(burst_len, rd_max_addr, rd_addr);
        // A port being reloaded this cycle is not granted from its stale address.
        wr_elig     = !wr_load && (wr_fifo_cnt >= wr_len);
        rd_elig     = read_valid && !rd_load &&
                      (({1'b0, rd_fifo_cnt} + {1'b0, rd_len}) <= DEPTH_X);
        len_ext     = {{(ADDR_W-LEN_W){1'b0}}, cmd_len};
        wr_next     = wr_addr + len_ext;
        rd_next     = rd_addr + len_ext;
        burst_done  = (state == ST_BUSY) && cmd_done;
        wr_inflight = ((state == ST_REQ) || (state == ST_BUSY)) && cmd_write;
        rd_inflight = ((state == ST_REQ) || (state == ST_BUSY)) && !cmd_write;
    end

    // Next-state logic and arbitration decision.
    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        grant_write = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sdram_init_done) begin
                    state_nxt = ST_ARB;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!sdram_init_done) begin
                    state_nxt = ST_IDLE;
                end else if (wr_elig || rd_elig) begin
                    grant     = 1'b1;
                    state_nxt = ST_REQ;
                    if (wr_elig && rd_elig) begin
`ifdef READ_URGENT_EN
                        if (rd_fifo_cnt < LEN_W'(URGENT_LVL)) begin
                            grant_write = 1'b0;
                        end else begin
                            grant_write = !last_grant_write;
                        end
`else
                        grant_write = !last_grant_write;
`endif
                    end else begin
                        grant_write = wr_elig;
                    end
                end else begin
                    state_nxt = ST_ARB;
                end
            end
            ST_REQ: begin
                if (cmd_ready) begin
                    state_nxt = ST_BUSY;
                end else begin
                    state_nxt = ST_REQ;
                end
            end
            ST_BUSY: begin
                if (cmd_done) begin
                    state_nxt = sdram_init_done ? ST_ARB : ST_IDLE;
                end else begin
                    state_nxt = ST_BUSY;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and latched command fields presented to the SDRAM core.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            cmd_valid        <= 1'b0;
            cmd_write        <= 1'b0;
            cmd_addr         <= {ADDR_W{1'b0}};
            cmd_len          <= {LEN_W{1'b0}};
            last_grant_write <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                cmd_valid        <= 1'b1;
                cmd_write        <= grant_write;
                last_grant_write <= grant_write;
                if (grant_write) begin
                    cmd_len  <= wr_len;
                    cmd_addr <= {(pingpong ? wr_bank : 1'b0), wr_addr[ADDR_W-2:0]};
                end else begin
                    cmd_len  <= rd_len;
                    cmd_addr <= {(pingpong ? rd_bank : 1'b0), rd_addr[ADDR_W-2:0]};
                end
            end else if ((state == ST_REQ) && cmd_ready) begin
                cmd_valid <= 1'b0;
            end else begin
                cmd_valid <= cmd_valid;
            end
        end
    end

    // Write port address, bank, deferred load and end-of-frame pulse.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            wr_addr       <= {ADDR_W{1'b0}};
            wr_bank       <= 1'b0;
            wr_load_pend  <= 1'b0;
            frame_wr_done <= 1'b0;
        end else begin
            frame_wr_done <= 1'b0;
            if (wr_inflight) begin
                if (burst_done) begin
                    wr_load_pend <= 1'b0;
                    if (wr_load || wr_load_pend) begin
                        wr_addr <= wr_min_addr;
                        wr_bank <= 1'b0;
                    end else if (wr_next >= wr_max_addr) begin
                        wr_addr       <= wr_min_addr;
                        frame_wr_done <= 1'b1;
                        wr_bank       <= pingpong ? !wr_bank : wr_bank;
                    end else begin
                        wr_addr <= wr_next;
                    end
                end else if (wr_load) begin
                    wr_load_pend <= 1'b1;
                end else begin
                    wr_load_pend <= wr_load_pend;
                end
            end else if (wr_load) begin
                wr_addr      <= wr_min_addr;
                wr_bank      <= 1'b0;
                wr_load_pend <= 1'b0;
            end else begin
                wr_load_pend <= 1'b0;
            end
        end
    end

    // Read port address, bank selection at frame wrap and deferred load.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            rd_addr      <= {ADDR_W{1'b0}};
            rd_bank      <= 1'b0;
            rd_load_pend <= 1'b0;
        end else begin
            if (rd_inflight) begin
                if (burst_done) begin
                    rd_load_pend <= 1'b0;
                    if (rd_load || rd_load_pend) begin
                        rd_addr <= rd_min_addr;
                        rd_bank <= 1'b0;
                    end else if (rd_next >= rd_max_addr) begin
                        rd_addr <= rd_min_addr;
                        // Follow the newest fully written frame.
                        rd_bank <= pingpong ? !wr_bank : 1'b0;
                    end else begin
                        rd_addr <= rd_next;
                    end
                end else if (rd_load) begin
                    rd_load_pend <= 1'b1;
                end else begin
                    rd_load_pend <= rd_load_pend;
                end
            end else if (rd_load) begin
                rd_addr      <= rd_min_addr;
                rd_bank      <= 1'b0;
                rd_load_pend <= 1'b0;
            end else begin
                rd_load_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed testbench for sdram_burst_scheduler: write frame sequencing with
// short final burst, ping-pong banks, read bank selection, round-robin
// alternation, command stability under back-pressure, deferred load,
// urgent-read arbitration and asynchronous reset mid-burst.
module tb_sdram_burst_scheduler;

    logic        ref_clk;
    logic        rst;
    logic        sdram_init_done;
    logic        read_valid;
    logic        pingpong;
    logic [9:0]  burst_len;
    logic [23:0] wr_min_addr;
    logic [23:0] wr_max_addr;
    logic [23:0] rd_min_addr;
    logic [23:0] rd_max_addr;
    logic        wr_load;
    logic        rd_load;
    logic [9:0]  wr_fifo_cnt;
    logic [9:0]  rd_fifo_cnt;
    logic        cmd_valid;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic [9:0]  cmd_len;
    logic        cmd_ready;
    logic        cmd_done;
    logic        frame_wr_done;

    int n_checks = 0;
    int n_pass   = 0;

    sdram_burst_scheduler dut (
        .ref_clk         (ref_clk),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .read_valid      (read_valid),
        .pingpong        (pingpong),
        .burst_len       (burst_len),
        .wr_min_addr     (wr_min_addr),
        .wr_max_addr     (wr_max_addr),
        .rd_min_addr     (rd_min_addr),
        .rd_max_addr     (rd_max_addr),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .wr_fifo_cnt     (wr_fifo_cnt),
        .rd_fifo_cnt     (rd_fifo_cnt),
        .cmd_valid       (cmd_valid),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cmd_ready       (cmd_ready),
        .cmd_done        (cmd_done),
        .frame_wr_done   (frame_wr_done)
    );

    // 100 MHz controller clock.
    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Wait for a command, check its fields, optionally hold off cmd_ready, then accept it.
    task automatic take(input string tag, input logic ew, input logic [23:0] ea,
                        input logic [9:0] el, input int hold);
        int n;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 100) begin
            @(negedge ref_clk);
            n++;
        end
        chk({tag, ".valid"}, 32'(cmd_valid), 32'd1);
        chk({tag, ".write"}, 32'(cmd_write), 32'(ew));
        chk({tag, ".addr"},  32'(cmd_addr),  32'(ea));
        chk({tag, ".len"},   32'(cmd_len),   32'(el));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge ref_clk);
            end
            chk({tag, ".hold_valid"}, 32'(cmd_valid), 32'd1);
            chk({tag, ".hold_write"}, 32'(cmd_write), 32'(ew));
            chk({tag, ".hold_addr"},  32'(cmd_addr),  32'(ea));
            chk({tag, ".hold_len"},   32'(cmd_len),   32'(el));
        end
        cmd_ready = 1'b1;
        @(negedge ref_clk);
        cmd_ready = 1'b0;
        chk({tag, ".drop"}, 32'(cmd_valid), 32'd0);
    endtask

    // Finish the accepted burst and check the end-of-frame pulse.
    task automatic complete(input string tag, input logic efwd);
        cmd_done = 1'b1;
        @(negedge ref_clk);
        cmd_done = 1'b0;
        chk({tag, ".fwd"}, 32'(frame_wr_done), 32'(efwd));
        if (efwd) begin
            @(negedge ref_clk);
            chk({tag, ".fwd_end"}, 32'(frame_wr_done), 32'd0);
        end
    endtask

    // Hard stop if something hangs beyond every bounded wait.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst             = 1'b1;
        sdram_init_done = 1'b0;
        read_valid      = 1'b0;
        pingpong        = 1'b0;
        burst_len       = 10'd256;
        wr_min_addr     = 24'd0;
        wr_max_addr     = 24'd600;
        rd_min_addr     = 24'd0;
        rd_max_addr     = 24'd600;
        wr_load         = 1'b0;
        rd_load         = 1'b0;
        wr_fifo_cnt     = 10'd300;
        rd_fifo_cnt     = 10'd0;
        cmd_ready       = 1'b0;
        cmd_done        = 1'b0;

        repeat (3) @(negedge ref_clk);
        chk("rst.valid", 32'(cmd_valid),     32'd0);
        chk("rst.write", 32'(cmd_write),     32'd0);
        chk("rst.addr",  32'(cmd_addr),      32'd0);
        chk("rst.len",   32'(cmd_len),       32'd0);
        chk("rst.fwd",   32'(frame_wr_done), 32'd0);
        rst = 1'b0;

        // No commands before init completes.
        repeat (6) @(negedge ref_clk);
        chk("noinit.valid", 32'(cmd_valid), 32'd0);
        sdram_init_done = 1'b1;
        @(negedge ref_clk);
        chk("init.lat", 32'(cmd_valid), 32'd0);

        // Single-frame writes with short final burst and wrap.
        take("w0", 1'b1, 24'd0, 10'd256, 0);     complete("w0", 1'b0);
        take("w1", 1'b1, 24'd256, 10'd256, 0);   complete("w1", 1'b0);
        take("w2", 1'b1, 24'd512, 10'd88, 0);    complete("w2", 1'b1);
        take("w3", 1'b1, 24'd0, 10'd256, 0);
        pingpong = 1'b1;
        complete("w3", 1'b0);
        // Ping-pong: bank toggles at each write frame end.
        take("w4", 1'b1, 24'd256, 10'd256, 0);   complete("w4", 1'b0);
        take("w5", 1'b1, 24'd512, 10'd88, 0);    complete("w5", 1'b1);
        take("w6", 1'b1, 24'h800000, 10'd256, 0); complete("w6", 1'b0);
        take("w7", 1'b1, 24'h800100, 10'd256, 0); complete("w7", 1'b0);
        take("w8", 1'b1, 24'h800200, 10'd88, 0);
        wr_fifo_cnt = 10'd0;
        read_valid  = 1'b1;
        rd_max_addr = 24'd300;
        complete("w8", 1'b1);

        // Reads only; read wrap picks bank ~wr_bank = 1.
        take("r0", 1'b0, 24'd0, 10'd256, 0);      complete("r0", 1'b0);
        take("r1", 1'b0, 24'd256, 10'd44, 0);     complete("r1", 1'b0);
        take("r2", 1'b0, 24'h800000, 10'd256, 0);
        wr_fifo_cnt = 10'd300;
        complete("r2", 1'b0);

        // Both eligible: alternation, with back-pressure on the first one.
        take("rr0", 1'b1, 24'h000000, 10'd256, 5); complete("rr0", 1'b0);
        take("rr1", 1'b0, 24'h800100, 10'd44, 0);  complete("rr1", 1'b0);
        take("rr2", 1'b1, 24'h000100, 10'd256, 0); complete("rr2", 1'b0);
        take("rr3", 1'b0, 24'h800000, 10'd256, 0); complete("rr3", 1'b0);
        take("rr4", 1'b1, 24'h000200, 10'd88, 0);
        // Load during the write burst replaces the wrap.
        wr_min_addr = 24'd100;
        rd_fifo_cnt = 10'd10;
        wr_load = 1'b1;
        @(negedge ref_clk);
        wr_load = 1'b0;
        complete("rr4", 1'b0);
        take("rr5", 1'b0, 24'h800100, 10'd44, 0); complete("rr5", 1'b0);
`ifdef READ_URGENT_EN
        take("urg", 1'b0, 24'h800000, 10'd256, 0);
        rd_fifo_cnt = 10'd500;
        complete("urg", 1'b0);
        take("ld", 1'b1, 24'd100, 10'd256, 0);    complete("ld", 1'b0);
`else
        take("ld", 1'b1, 24'd100, 10'd256, 0);    complete("ld", 1'b0);
`endif

        // Asynchronous reset while a command is pending.
        n = 0;
        while (cmd_valid !== 1'b1 && n < 100) begin
            @(negedge ref_clk);
            n++;
        end
        chk("arst.pre", 32'(cmd_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", 32'(cmd_valid), 32'd0);
        chk("arst.addr",  32'(cmd_addr),  32'd0);
        chk("arst.len",   32'(cmd_len),   32'd0);
        @(negedge ref_clk);
        chk("arst.fwd", 32'(frame_wr_done), 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
